// File: rtl/cordic_vectoring_if.sv
// Request/result bundle for the vectoring CORDIC: operands and start in,
// magnitude/phase with done/busy status out.
interface cordic_vectoring_if #(
    parameter int WIDTH       = 16,
    parameter int ANGLE_WIDTH = 32
);
    logic                          start;
    logic signed [WIDTH-1:0]       x_in;
    logic signed [WIDTH-1:0]       y_in;
    logic        [WIDTH-1:0]       magnitude;
    logic signed [ANGLE_WIDTH-1:0] phase;
    logic                          done;
    logic                          busy;

    modport master (output start, x_in, y_in, input magnitude, phase, done, busy);
    modport slave  (input start, x_in, y_in, output magnitude, phase, done, busy);
endinterface

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: one micro-rotation per cycle, returns the
// gain-compensated magnitude and atan2(y, x) in the rotation block's angle format.
module cordic_vectoring #(
    parameter int WIDTH       = 16,
    parameter int ITERATIONS  = 15,
    parameter int ANGLE_WIDTH = 32
) (
    input logic               clock,
    input logic               reset_n,
    cordic_vectoring_if.slave bus
);
    localparam int FRAC_BITS = ANGLE_WIDTH - 3;
    localparam int XW        = WIDTH + 2;
    localparam int PW        = 2 * WIDTH + 2;
    localparam logic [4:0] LAST = 5'(ITERATIONS - 1);

    typedef logic signed [ANGLE_WIDTH-1:0] angle_t;
    typedef logic signed [XW-1:0]          coord_t;
    typedef enum logic [1:0] {IDLE, PREROTATE, ITERATE, SCALE} state_t;

    localparam longint PI_ROUND   = longint'(3.14159265358979323846 * (2.0 ** FRAC_BITS));
    localparam angle_t PI         = angle_t'(PI_ROUND);
    localparam longint GAIN_ROUND = longint'(0.6072529350 * (2.0 ** (WIDTH - 1)));
    localparam logic signed [PW-1:0] GAIN = PW'(GAIN_ROUND);

    // Arctangent table is sized to the full 5-bit counter range so the
    // counter indexes it directly; entries past ITERATIONS are never reached.
    angle_t atan_lut [32];
    for (genvar g = 0; g < 32; g++) begin : g_atan
        localparam longint ENTRY = longint'($atan(2.0 ** (-g)) * (2.0 ** FRAC_BITS));
        assign atan_lut[g] = angle_t'(ENTRY);
    end

    state_t            state, state_next;
    coord_t            x_r, y_r;
    angle_t            z_r;
    logic [4:0]        count;
    logic              zero;
    logic signed [PW-1:0] x_ext, product, scaled;
    logic [WIDTH-1:0]  mag_sat;

    // NOTE: state and every other flop are written with <= so all registers
    // update together from pre-edge values, which the micro-rotation relies on.
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (bus.start) state_next = PREROTATE;
            PREROTATE: state_next = ITERATE;
            ITERATE:   if (count == LAST) state_next = SCALE;
            SCALE:     state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // NOTE: the x/y/z datapath has no reset; it is always loaded before use,
    // and control (state, counter, outputs) alone decides what is visible.
    always_ff @(posedge clock) begin
        case (state)
            IDLE: begin
                if (bus.start) begin
                    x_r <= XW'(bus.x_in);
                    y_r <= XW'(bus.y_in);
                end
            end
            PREROTATE: begin
                // Fold the left half-plane onto the right; the ±π choice keeps
                // the negative real axis at +π.
                if (x_r[XW-1]) begin
                    x_r <= -x_r;
                    y_r <= -y_r;
                    z_r <= y_r[XW-1] ? -PI : PI;
                end else begin
                    z_r <= '0;
                end
            end
            ITERATE: begin
                if (y_r[XW-1]) begin
                    x_r <= x_r - (y_r >>> count);
                    y_r <= y_r + (x_r >>> count);
                    z_r <= z_r - atan_lut[count];
                end else begin
                    x_r <= x_r + (y_r >>> count);
                    y_r <= y_r - (x_r >>> count);
                    z_r <= z_r + atan_lut[count];
                end
            end
            default: ;
        endcase
    end

    assign x_ext   = PW'(x_r);
    assign product = x_ext * GAIN;
    assign scaled  = product >>> (WIDTH - 1);

    always_comb begin
        mag_sat = scaled[WIDTH-1:0];
        if (scaled[PW-1])               mag_sat = '0;
        else if (|scaled[PW-2:WIDTH])   mag_sat = '1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count         <= '0;
            zero          <= 1'b0;
            bus.magnitude <= '0;
            bus.phase     <= '0;
            bus.done      <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.busy <= (state == PREROTATE) || (state == ITERATE);
            case (state)
                PREROTATE: begin
                    count <= '0;
                    zero  <= (x_r == '0) && (y_r == '0);
                end
                ITERATE: count <= count + 5'd1;
                SCALE: begin
                    // atan2(0, 0) has no meaning; report an exact zero vector.
                    bus.magnitude <= zero ? '0 : mag_sat;
                    bus.phase     <= zero ? '0 : z_r;
                    bus.done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: expected magnitude/phase/latency are
// modelled with real arithmetic when a request is issued and checked on done.
module tb_cordic_vectoring;
    localparam int    WIDTH       = 16;
    localparam int    ITERATIONS  = 15;
    localparam int    ANGLE_WIDTH = 32;
    localparam int    FRAC_BITS   = ANGLE_WIDTH - 3;
    localparam int    LATENCY     = ITERATIONS + 2;
    localparam real   M_PI        = 3.14159265358979323846;

    typedef struct {
        longint mag;
        longint mag_tol;
        longint ph;
        longint ph_tol;
        longint due;
    } exp_t;

    logic clock;
    logic reset_n;
    int   cyc = 0;
    int   checks_total  = 0;
    int   checks_passed = 0;
    int   expected_dones = 0;
    int   seen_dones     = 0;
    exp_t sb[$];

    cordic_vectoring_if #(.WIDTH(WIDTH), .ANGLE_WIDTH(ANGLE_WIDTH)) bus ();

    cordic_vectoring #(
        .WIDTH(WIDTH), .ITERATIONS(ITERATIONS), .ANGLE_WIDTH(ANGLE_WIDTH)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp,
                         input longint tol = 0);
        longint diff;
        diff = (got > exp) ? got - exp : exp - got;
        checks_total++;
        if (diff <= tol) checks_passed++;
        else $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d",
                      tag, got, exp, tol, cyc);
    endtask

    // Called at a negedge while start is being driven; acceptance is the next posedge.
    task automatic push(input int x, input int y, input longint due, input longint ph_tol);
        exp_t e;
        real  xr, yr;
        xr = real'(x);
        yr = real'(y);
        e.mag     = longint'($sqrt(xr * xr + yr * yr));
        e.ph      = longint'($atan2(yr, xr) * (2.0 ** FRAC_BITS));
        e.mag_tol = (x == 0 && y == 0) ? 0 : 6;
        e.ph_tol  = (x == 0 && y == 0) ? 0 : ph_tol;
        e.due     = due;
        sb.push_back(e);
        expected_dones++;
    endtask

    task automatic issue(input int x, input int y, input longint ph_tol);
        bus.start = 1'b1;
        bus.x_in  = 16'(x);
        bus.y_in  = 16'(y);
        push(x, y, longint'(cyc) + LATENCY + 1, ph_tol);
        @(negedge clock);
        bus.start = 1'b0;
        bus.x_in  = 16'(-x);
        bus.y_in  = 16'(y + 1);
        @(negedge clock);
        check("busy_running", longint'(bus.busy), 1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < LATENCY + 20 && !seen; i++) begin
            @(negedge clock);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input int x, input int y, input longint ph_tol);
        issue(x, y, ph_tol);
        wait_done();
        @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (bus.done) begin
            seen_dones++;
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("magnitude", longint'(bus.magnitude), e.mag, e.mag_tol);
                check("phase", longint'(bus.phase), e.ph, e.ph_tol);
                check("latency", longint'(cyc), e.due);
                check("busy_in_done", longint'(bus.busy), 0);
            end
        end
    end

    initial begin
        int n;
        bus.start = 1'b0;
        bus.x_in  = '0;
        bus.y_in  = '0;
        reset_n   = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_magnitude", longint'(bus.magnitude), 0);
        check("reset_phase", longint'(bus.phase), 0);
        check("reset_done", longint'(bus.done), 0);
        check("reset_busy", longint'(bus.busy), 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Directed vectors, including the ±π branch cut and the most negative input
        run_op(16384, 0, 65536);
        run_op(11585, 11585, 65536);
        run_op(-16384, 0, 65536);
        run_op(-11585, -11585, 65536);
        run_op(0, 0, 0);
        run_op(-32768, -32768, 65536);
        run_op(0, 20000, 65536);
        run_op(0, -20000, 65536);
        run_op(32767, 32767, 65536);

        for (int i = 0; i < 4; i++) begin
            int x, y;
            x = int'($urandom_range(16384, 23000));
            y = int'($urandom_range(16384, 23000));
            if ($urandom_range(0, 1) == 1) x = -x;
            if ($urandom_range(0, 1) == 1) y = -y;
            run_op(x, y, 131072);
        end

        // A second start while busy must be ignored
        issue(20000, -5000, 65536);
        repeat (3) @(negedge clock);
        bus.start = 1'b1;
        bus.x_in  = 16'(-7000);
        bus.y_in  = 16'(9000);
        @(negedge clock);
        bus.start = 1'b0;
        wait_done();

        // Back-to-back: start asserted in the done cycle itself
        issue(-9000, 18000, 65536);
        wait_done();
        issue(15000, -15000, 65536);
        wait_done();
        @(negedge clock);

        // start held high: each operation uses the operands present at its own accept edge
        n = cyc;
        bus.start = 1'b1;
        bus.x_in  = 16'(12000);
        bus.y_in  = 16'(-21000);
        push(12000, -21000, longint'(n) + LATENCY + 1, 65536);
        @(negedge clock);
        bus.x_in = 16'(-20000);
        bus.y_in = 16'(4000);
        push(-20000, 4000, longint'(n) + 2 * (LATENCY + 1), 65536);
        repeat (LATENCY + 1) @(negedge clock);
        bus.start = 1'b0;
        wait_done();
        @(negedge clock);

        // Reset in the middle of the iterations aborts with no done
        issue(17000, 17000, 65536);
        repeat (6) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("abort_magnitude", longint'(bus.magnitude), 0);
        check("abort_phase", longint'(bus.phase), 0);
        check("abort_done", longint'(bus.done), 0);
        check("abort_busy", longint'(bus.busy), 0);
        sb.delete();
        expected_dones--;
        reset_n = 1'b1;
        repeat (LATENCY + 8) @(negedge clock);
        run_op(-15000, 21000, 65536);

        repeat (LATENCY + 5) @(negedge clock);
        check("queue_empty", longint'(sb.size()), 0);
        check("done_count", longint'(seen_dones), longint'(expected_dones));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
